// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the LED pattern generator: mode encoding and
// the pattern each mode starts from.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ALT   = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_BLINK = 2'd3
  } led_mode_e;

  // Widest LED bank the seed helper can describe; callers truncate to NUM_LEDS.
  localparam int unsigned MAX_LEDS = 64;

  function automatic logic [MAX_LEDS-1:0] seed_pattern(input led_mode_e m,
                                                       input int unsigned n);
    logic [MAX_LEDS-1:0] s;
    s = '0;
    case (m)
      MODE_ALT: begin
        for (int unsigned i = 0; i < MAX_LEDS; i += 2) begin
          if (i < n) s[i] = 1'b1;
        end
      end
      MODE_CHASE: s[0] = 1'b1;
      default:    s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// Divides the board clock into pattern steps: tick is high on the last
// enabled cycle of each DIV-cycle period, unless a clear is pending.
module tick_prescaler #(
  parameter int unsigned DIV = 2000000
) (
  input  logic cloooock,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge cloooock) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: mode-selected pattern advanced by a
// prescaler, gated by a free-running PWM for global brightness.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 2,
  parameter int unsigned DIV      = 2000000,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                cloooock,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty,
  output logic [NUM_LEDS-1:0] led,
  output logic                step
);

  led_mode_e           mode_in, mode_q;
  logic                reload, tick, gate;
  logic [NUM_LEDS-1:0] seed, pat_q, pat_d, pat_next, led_q, led_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                step_q;

  assign mode_in = led_mode_e'(mode);
  assign reload  = (mode_in != mode_q);
  assign seed    = NUM_LEDS'(seed_pattern(mode_in, NUM_LEDS));

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .cloooock (cloooock),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (reload),
    .tick     (tick)
  );

  always_comb begin
    pat_next = '0;
    case (mode_q)
      MODE_ALT, MODE_BLINK: pat_next = ~pat_q;
      MODE_CHASE:           pat_next = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
      default:              pat_next = '0;
    endcase
  end

  // Reload outranks a coincident tick; the prescaler already masks tick then.
  always_comb begin
    pat_d = pat_q;
    if (reload)    pat_d = seed;
    else if (tick) pat_d = pat_next;
  end

  assign gate  = (duty == '1) || (pwm_cnt_q < duty);
  assign led_d = pat_q & {NUM_LEDS{gate}};

  always_ff @(posedge cloooock) begin
    if (!rst_n) begin
      mode_q    <= MODE_OFF;
      pat_q     <= '0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
      step_q    <= 1'b0;
    end else begin
      mode_q    <= mode_in;
      pat_q     <= pat_d;
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      led_q     <= led_d;
      step_q    <= tick;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with NUM_LEDS=4, DIV=4, PWM_BITS=4.
module tb_led_pattern_gen;

  logic       cloooock = 1'b0;
  logic       rst_n    = 1'b0;
  logic       en       = 1'b1;
  logic [1:0] mode     = 2'd1;
  logic [3:0] duty     = 4'd15;
  logic [3:0] led;
  logic       step;

  int n_tests = 0;
  int n_fail  = 0;

  led_pattern_gen #(.NUM_LEDS(4), .DIV(4), .PWM_BITS(4)) dut (
    .cloooock (cloooock),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .duty     (duty),
    .led      (led),
    .step     (step)
  );

  always #5 cloooock = ~cloooock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic edge1;
    @(posedge cloooock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hi;
    int bad;

    // Reset held with mode=ALT, duty=15
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("rst_led", led, 4'b0000);
      chk("rst_step", step, 1'b0);
    end
    rst_n = 1'b1;
    edge1();                                   // reload edge
    chk("rel_led_first", led, 4'b0000);
    chk("rel_step_first", step, 1'b0);

    // ALT pattern: first k=0 is the edge after reload
    for (int k = 0; k < 12; k++) begin
      edge1();
      chk("alt_led", led, ((k / 4) % 2 == 1) ? 4'b1010 : 4'b0101);
      chk("alt_step", step, (k % 4 == 3) ? 1'b1 : 1'b0);
    end

    // CHASE
    mode = 2'd2;
    edge1();                                   // reload edge
    chk("chase_reload_step", step, 1'b0);
    for (int k = 0; k < 20; k++) begin
      edge1();
      chk("chase_led", led, 4'b0001 << ((k / 4) % 4));
      chk("chase_step", step, (k % 4 == 3) ? 1'b1 : 1'b0);
    end

    // Enable hold: pattern now 0010, two counted cycles then en low
    edge1();
    chk("hold_pre_led", led, 4'b0010);
    edge1();
    chk("hold_pre_step", step, 1'b0);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      edge1();
      chk("hold_led", led, 4'b0010);
      chk("hold_step", step, 1'b0);
    end
    en = 1'b1;
    edge1();
    chk("resume_step1", step, 1'b0);
    edge1();
    chk("resume_step2", step, 1'b1);
    chk("resume_led2", led, 4'b0010);
    edge1();
    chk("resume_led3", led, 4'b0100);
    chk("resume_step3", step, 1'b0);

    // BLINK: reach all-ones phase, freeze it, then sweep duty
    mode = 2'd3;
    edge1();                                   // reload edge
    for (int k = 0; k < 4; k++) begin
      edge1();
      chk("blink_step", step, (k == 3) ? 1'b1 : 1'b0);
    end
    en   = 1'b0;
    duty = 4'd4;
    hi = 0; bad = 0;
    for (int k = 0; k < 16; k++) begin
      edge1();
      if (led == 4'b1111) hi++;
      else if (led != 4'b0000) bad++;
    end
    chk("pwm4_hi_cycles", hi, 4);
    chk("pwm4_partial", bad, 0);
    duty = 4'd0;
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      edge1();
      if (led != 4'b0000) hi++;
    end
    chk("pwm0_lit_cycles", hi, 0);
    duty = 4'd15;
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      edge1();
      if (led == 4'b1111) hi++;
    end
    chk("pwm15_full_cycles", hi, 16);

    // CHASE -> ALT landing on the tick cycle
    en   = 1'b1;
    mode = 2'd2;
    edge1();                                   // reload, cnt=0
    edge1();
    edge1();
    edge1();                                   // cnt=3: next edge would tick
    mode = 2'd1;
    edge1();                                   // reload wins
    chk("coll_step", step, 1'b0);
    for (int k = 0; k < 4; k++) begin
      edge1();
      chk("coll_led", led, 4'b0101);
      chk("coll_next_step", step, (k == 3) ? 1'b1 : 1'b0);
    end
    edge1();
    chk("coll_led_after", led, 4'b1010);

    // Reset mid-CHASE
    mode = 2'd2;
    for (int k = 0; k < 6; k++) edge1();
    chk("midchase_led", led, 4'b0010);
    rst_n = 1'b0;
    edge1();
    edge1();
    chk("midrst_led", led, 4'b0000);
    chk("midrst_step", step, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised multi-channel LED pattern generator. Supersedes the fixed two-LED alternating blinker. An internal prescaler divides the board clock into pattern steps. A runtime-selectable mode chooses off, alternate, chase or all-blink. A PWM gate applies a global brightness. It sits at the top level and drives the board LED pins directly.

## Interface
- `NUM_LEDS`, default 2: number of LED outputs, must be ≥2.
- `DIV`, default 2000000: clock cycles per pattern step, must be ≥2.
- `PWM_BITS`, default 4: brightness resolution in bits.
- `cloooock`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `en`, in, 1: high = prescaler runs; low = prescaler and pattern hold.
- `mode`, in, 2: 0 OFF, 1 ALT, 2 CHASE, 3 BLINK.
- `duty`, in, PWM_BITS: brightness. 0 = dark; all-ones = full on.
- `led`, out, NUM_LEDS: registered LED drive, active-high.
- `step`, out, 1: registered one-cycle pulse on each pattern advance.

## Operation
- **State:** prescaler count `cnt` (0..DIV-1), pattern register `pat[NUM_LEDS-1:0]`, registered mode `mode_q`, free-running `pwm_cnt` (PWM_BITS bits).
- **Reset**, `rst_n` low at an edge: `cnt`=0, `pat`=0, `mode_q`=OFF, `pwm_cnt`=0, `led`=0, `step`=0. Reset dominates every other event.
- **Reload:** when `mode` ≠ `mode_q`, `mode_q`←`mode`, `pat`←seed(mode), `cnt`←0, `step`=0.
  - Reload takes effect regardless of `en`.
  - Reload has priority over a coincident tick: no advance and no step on that cycle.
- **Seeds:**
  - OFF: all 0.
  - ALT: bit0=1, alternating (…0101).
  - CHASE: one-hot bit0.
  - BLINK: all 0.
- **Tick:** `en`=1, no reload and `cnt`==DIV-1. Then `cnt`←0, `pat`←next(pat), `step`=1. Otherwise, with `en`=1, `cnt` increments.
- **Advance rules:**
  - OFF: stays 0.
  - ALT: bitwise invert.
  - CHASE: rotate left; MSB wraps to bit0.
  - BLINK: bitwise invert.
- **`en`=0:** `cnt` and `pat` frozen; `step`=0; `pwm_cnt` keeps running.
- **PWM:** `pwm_cnt` increments every cycle and wraps at 2^PWM_BITS.
  - gate = (`duty`==all-ones) OR (`pwm_cnt` < `duty`).
  - `led`←`pat` AND replicate(gate).
- **Widths:** `cnt` is $clog2(DIV) bits. The PWM compare is unsigned, PWM_BITS wide.

## Timing
- `step` and the new `pat` value appear on the same edge.
- `led` reflects `pat` and gate one cycle later (1-cycle output latency).
- A step occurs exactly DIV enabled cycles after reload, then every DIV enabled cycles.
- Reset release with `mode`≠OFF: reload at the first edge with `rst_n` high. `led` shows the seed (if gated on) at the following edge.
- PWM period is 2^PWM_BITS cycles, independent of `en` and mode.
- A `mode` change is acted on at the next edge. A change shorter than one cycle is not guaranteed to be seen.

## Structure
- **Package `led_pattern_pkg`:**
  - typedef enum logic [1:0] `led_mode_e` {MODE_OFF, MODE_ALT, MODE_CHASE, MODE_BLINK}.
  - A seed function of (mode, NUM_LEDS).
- **Sub-module `tick_prescaler`:**
  - Parameter DIV.
  - Ports: `cloooock`, `rst_n`, `en`, `clr`, `tick`.
  - Contains `cnt`; `clr` is driven by reload.
- Top contains the pattern register, mode register, PWM counter and output registers.

## Test plan
All scenarios use NUM_LEDS=4, DIV=4, PWM_BITS=4.
1. `rst_n` low for 3 cycles with `mode`=ALT, `duty`=15 -> `led`=0000 and `step`=0 throughout. Release -> `led`=0101 two edges later.
2. ALT, `en`=1, `duty`=15 -> `led` alternates 0101/1010. `step` pulses once every 4 cycles, one cycle before each `led` change.
3. CHASE -> `led` goes 0001→0010→0100→1000→0001 (wrap), 4 cycles per step.
4. `en`=0 after 2 counted cycles, held 10 cycles, then `en`=1 -> no `step` while low. Next `step` follows 2 more enabled cycles; pattern unchanged during the hold.
5. BLINK in its all-ones phase with `duty`=4 -> each `led` high exactly 4 of every 16 cycles. `duty`=0 -> `led`=0000 always. `duty`=15 -> `led`=1111 constantly.
6. `mode` changes CHASE→ALT on the tick cycle -> no `step`, `pat`=0101, next `step` 4 cycles later. Later, `rst_n` low mid-CHASE -> `led`=0000 within 2 edges.
